// File: rtl/sbox_arbiter.sv
// Round-robin arbiter sharing one SBOX lookup port between SubBytes (port 0) and
// key expansion (port 1), with per-requester lock bursts capped at MAX_BURST grants.
module sbox_arbiter #(
    parameter int MAX_BURST = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic       req0_lock,
    input  logic [7:0] req0_byte,
    input  logic       req0_en_de,
    input  logic       req1_valid,
    input  logic       req1_lock,
    input  logic [7:0] req1_byte,
    input  logic       req1_en_de,
    output logic       req0_gnt,
    output logic       req1_gnt,
    output logic       rsp0_valid,
    output logic [7:0] rsp0_byte,
    output logic       rsp1_valid,
    output logic [7:0] rsp1_byte,
    output logic [7:0] sbox_in,
    output logic       sbox_en_de_in,
    output logic       ce,
    output logic       re,
    input  logic [7:0] sbox_out,
    output logic       owner,
    output logic       busy
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             rr_last;
    logic             rr_next;
    logic [CNT_W-1:0] burst_cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] cnt_inc;
    logic             gnt0;
    logic             gnt1;
    logic             gnt_any;
    logic             gnt_port;
    logic             gnt_lock;
    logic             own_lock;
    logic             tag_vld_p1;
    logic             tag_port_p1;

    // Grant decode; forced low while reset is asserted so all outputs clear at once
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        case (state)
            IDLE: begin
                if (req0_valid && req1_valid) begin
                    gnt0 = rr_last;
                    gnt1 = !rr_last;
                end else begin
                    gnt0 = req0_valid;
                    gnt1 = req1_valid;
                end
            end
            OWN0:    gnt0 = req0_valid;
            OWN1:    gnt1 = req1_valid;
            default: ;
        endcase
        if (rst) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
    end

    assign gnt_any  = gnt0 | gnt1;
    assign gnt_port = gnt1;
    assign gnt_lock = gnt1 ? req1_lock : req0_lock;
    assign own_lock = (state == OWN1) ? req1_lock : req0_lock;
    assign cnt_inc  = burst_cnt + CNT_ONE;

    always_comb begin
        state_next = state;
        cnt_next   = burst_cnt;
        rr_next    = rr_last;
        if (gnt_any) begin
            rr_next = gnt_port;
        end
        case (state)
            IDLE: begin
                if (gnt_any && gnt_lock && (MAX_BURST > 1)) begin
                    state_next = gnt_port ? OWN1 : OWN0;
                    cnt_next   = CNT_ONE;
                end
            end
            OWN0, OWN1: begin
                if (gnt_any) begin
                    // Dropping lock or reaching the cap both end the burst on this grant
                    if (!own_lock || (cnt_inc == CNT_MAX)) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_inc;
                    end
                end else if (!own_lock) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rr_last     <= 1'b1;
            burst_cnt   <= '0;
            busy        <= 1'b0;
            owner       <= 1'b0;
            tag_vld_p1  <= 1'b0;
            tag_port_p1 <= 1'b0;
        end else begin
            state       <= state_next;
            rr_last     <= rr_next;
            burst_cnt   <= cnt_next;
            busy        <= (state_next != IDLE);
            owner       <= (state_next == OWN1);
            tag_vld_p1  <= gnt_any;
            tag_port_p1 <= gnt_port;
        end
    end

    assign req0_gnt      = gnt0;
    assign req1_gnt      = gnt1;
    assign sbox_in       = gnt0 ? req0_byte : (gnt1 ? req1_byte : 8'h00);
    assign sbox_en_de_in = gnt0 ? req0_en_de : (gnt1 ? req1_en_de : 1'b0);
    assign ce            = gnt_any;
    assign re            = gnt_any;

    // p1: SBOX result returns one cycle after the grant; route it by the tag
    assign rsp0_valid = tag_vld_p1 & ~tag_port_p1;
    assign rsp1_valid = tag_vld_p1 & tag_port_p1;
    assign rsp0_byte  = rsp0_valid ? sbox_out : 8'h00;
    assign rsp1_byte  = rsp1_valid ? sbox_out : 8'h00;

endmodule

// File: doc/sbox_arbiter.md
# sbox_arbiter

Shares the single SBOX lookup port between two requesters: the SubBytes datapath (port 0) and the key-expansion engine (port 1). It arbitrates round-robin per lookup, lets a requester lock the SBOX for a burst such as the 16-byte SubBytes sweep, and caps any burst at MAX_BURST grants. It routes each 1-cycle-latency SBOX result back to the requester that issued it. The block sits between the round datapaths and the SBOX module and is the only driver of the SBOX control inputs.

## Interface
- MAX_BURST, 16, maximum consecutive grants to one locked owner before a forced release (legal range 1..255).
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid / req1_valid  in  1  lookup request.
- req0_lock / req1_lock  in  1  request to keep ownership after this grant.
- req0_byte / req1_byte  in  8  byte to substitute.
- req0_en_de / req1_en_de  in  1  1 = forward SBOX, 0 = inverse SBOX.
- req0_gnt / req1_gnt  out  1  combinational grant; the byte is consumed this cycle.
- rsp0_valid / rsp1_valid  out  1  registered; high the cycle after the matching grant.
- rsp0_byte / rsp1_byte  out  8  equals sbox_out while the matching rsp valid is high, else 0.
- sbox_in  out  8  byte to the SBOX.
- sbox_en_de_in  out  1  mode to the SBOX.
- ce, re  out  1  SBOX enables; both high exactly in grant cycles.
- sbox_out  in  8  SBOX result, valid one cycle after ce/re.
- owner  out  1  registered; the current lock owner, meaningful only when busy=1.
- busy  out  1  registered; high while state is OWN0 or OWN1.

## Operation
- State machine: IDLE, OWN0, OWN1.
- Registered state:
  - rr_last: last granted port; resets to 1.
  - burst_cnt: width clog2(MAX_BURST+1), resets to 0.
  - rsp tag flops.
- Arbitration in IDLE:
  - One requester valid: that requester is granted.
  - Both valid: grant the port != rr_last.
  - rr_last updates to the granted port.
- Lock entry from IDLE: if the granted requester's lock=1 and MAX_BURST>1, go to OWNx with burst_cnt=1. With MAX_BURST=1, stay in IDLE.
- Behaviour in OWNx:
  - Only port x may be granted; the other port waits with gnt=0.
  - x valid=1: grant, burst_cnt+1.
  - Return to IDLE, burst_cnt=0, when x's lock=0 in the grant cycle (that grant is the last of the burst) or when this grant makes burst_cnt reach MAX_BURST (forced release).
- Bubble in OWNx: x valid=0 and lock=1 gives no grant; state and count are held. x valid=0 and lock=0 returns to IDLE with no grant.
- Lock is ignored on any cycle with valid=0 in IDLE.
- Datapath on a grant: sbox_in=granted byte, sbox_en_de_in=granted en_de, ce=re=1. With no grant, all of these are 0.
- Response routing: a tag flop records valid and port for each grant. The next cycle it raises the matching rsp valid and presents sbox_out on the matching rsp byte; the other rsp byte reads 0.
- A grant and a response for the same or different ports may occur in the same cycle; full throughput is one lookup per cycle.

## Timing
- Reset values: all outputs 0; state IDLE; rr_last=1 (port 0 wins the first tie); burst_cnt=0; tags cleared.
- Reset mid-operation is asynchronous: outputs clear immediately, and a response pending from the previous cycle is dropped (no rsp valid after rst falls).
- Grant latency: 0 cycles, combinational from valid, state and rr_last.
- Response latency: exactly 1 cycle after the grant.
- Forced-release fairness: after a forced release rr_last = owner, so the other port wins an immediate tie. The former owner may re-lock on its next grant.
- A requester must hold valid, byte and en_de stable until it sees gnt.

## Test plan
- Reset then a single request: req0 byte 0x53, en_de=1 -> gnt0 in the same cycle, sbox_in=0x53, ce=re=1; next cycle rsp0_valid=1, rsp0_byte=0xED. Inverse check: req1 byte 0x63, en_de=0 -> rsp1_byte=0x00.
- Tie without lock: both valid for 6 cycles -> grants 0,1,0,1,0,1; rsp bytes routed to the correct ports.
- Locked SubBytes burst: req0 locks bytes 0x00..0x0F, lock dropped on 0x0F; req1 valid from cycle 2 -> req1 is first granted the cycle after req0's 16th grant. rsp0 sequence 63,7C,77,7B,...,76; busy=1, owner=0 throughout the burst.
- Forced release (MAX_BURST=16): req0 holds valid and lock for 20 cycles, req1 valid -> 16 req0 grants, then one req1 grant, then req0 re-locks.
- Owner bubble: in OWN0, req0 valid=0 and lock=1 for 3 cycles, req1 valid -> no grants, ce=0, burst_cnt unchanged; req0 then resumes.
- Async reset at the 7th burst grant -> outputs 0 immediately, no rsp the following cycle; after release a tie goes to req0.
